// File: rtl/writeback_queue.sv
// Writeback queue: buffers register-file writes and issues them in FIFO order.
// Pending writes (queued or just issued) can be probed for forwarding.
module writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0]                in_reg,
  input  logic [31:0]               in_data,
  input  logic                      drain_en,
  output logic                      regWrite,
  output logic [4:0]                writeReg,
  output logic [31:0]               writeData,
  input  logic [4:0]                lookup_reg,
  output logic                      lookup_hit,
  output logic [31:0]               lookup_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]    reg_q  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          regWrite_q, regWrite_d;
  logic [4:0]    writeReg_q, writeReg_d;
  logic [31:0]   writeData_q, writeData_d;

  logic          enq;
  logic          pop;
  logic [AW-1:0] idx;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full;
  assign count    = count_q;

  // Register-0 writes finish the handshake but never occupy a slot
  assign enq = in_valid && in_ready && (in_reg != 5'd0);
  assign pop = drain_en && !empty;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    regWrite_d  = 1'b0;
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    if (enq) begin
      tail_d = tail_q + AW'(1);
    end
    if (pop) begin
      head_d      = head_q + AW'(1);
      regWrite_d  = 1'b1;
      writeReg_d  = reg_q[head_q];
      writeData_d = data_q[head_q];
    end
    unique case ({enq, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      regWrite_q  <= regWrite_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      reg_q[tail_q]  <= in_reg;
      data_q[tail_q] <= in_data;
    end
  end

  assign regWrite  = regWrite_q;
  assign writeReg  = writeReg_q;
  assign writeData = writeData_q;

  // Scan oldest to newest so the youngest match overrides
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    if (lookup_reg != 5'd0) begin
      if (regWrite_q && (writeReg_q == lookup_reg)) begin
        lookup_hit  = 1'b1;
        lookup_data = writeData_q;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        idx = head_q + AW'(i);
        if ((CW'(i) < count_q) && (reg_q[idx] == lookup_reg)) begin
          lookup_hit  = 1'b1;
          lookup_data = data_q[idx];
        end
      end
    end
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit, producer presents a write request.
REQ-005 The block SHALL have port in_ready, output, 1 bit, queue can accept a request this cycle.
REQ-006 The block SHALL have port in_reg, input, 5 bits, destination register address.
REQ-007 The block SHALL have port in_data, input, 32 bits, destination register data.
REQ-008 The block SHALL have port drain_en, input, 1 bit, permits one entry to be issued to the register file this cycle.
REQ-009 The block SHALL have port regWrite, output, 1 bit, register-file write enable.
REQ-010 The block SHALL have port writeReg, output, 5 bits, register-file write address.
REQ-011 The block SHALL have port writeData, output, 32 bits, register-file write data.
REQ-012 The block SHALL have port lookup_reg, input, 5 bits, register address probed for a pending write.
REQ-013 The block SHALL have port lookup_hit, output, 1 bit, a write to lookup_reg is pending.
REQ-014 The block SHALL have port lookup_data, output, 32 bits, data of the youngest pending write to lookup_reg.
REQ-015 The block SHALL have port count, output, clog2(DEPTH)+1 bits, number of occupied entries.
REQ-016 The block SHALL have ports empty and full, both outputs, 1 bit each, meaning count==0 and count==DEPTH respectively.

Function
REQ-017 in_ready SHALL be combinationally !full; a push SHALL occur at a rising edge where in_valid && in_ready.
REQ-018 A push with in_reg==0 SHALL complete the handshake but SHALL NOT be enqueued (register 0 writes dropped).
REQ-019 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle.
REQ-020 A pop SHALL occur at a rising edge where drain_en && !empty; the head entry is removed, in FIFO order.
REQ-021 regWrite, writeReg and writeData SHALL be registered; at a pop edge they load 1, head reg and head data; at any other edge regWrite loads 0 and writeReg/writeData hold.
REQ-022 regWrite SHALL be high for exactly one cycle per popped entry; back-to-back pops give consecutive one-cycle pulses.
REQ-023 Latency: an entry pushed into an empty queue at edge N with drain_en high SHALL be popped at edge N+1, giving regWrite=1 during cycle N+1..N+2.
REQ-024 A push and a pop in the same cycle SHALL leave count unchanged; head and tail pointers SHALL wrap modulo DEPTH.
REQ-025 lookup_hit/lookup_data SHALL be combinational over all occupied entries plus the output register while regWrite=1; the youngest matching write SHALL win (newest queued entry over older entries over the output register).
REQ-026 lookup_reg==0 or no match SHALL give lookup_hit=0 and lookup_data=0.
REQ-027 A request being pushed in the current cycle SHALL NOT be visible to lookup until the following cycle.

Reset
REQ-028 Asserting reset SHALL immediately clear head, tail and count, drop all pending entries, and drive regWrite=0, writeReg=0, writeData=0, empty=1, full=0, in_ready=1, lookup_hit=0.
REQ-029 Reset asserted mid-operation SHALL discard queued entries without issuing them; the first edge after deassertion behaves as from an empty queue.

Verification
REQ-030 Push (r5, 0x11111111) with drain_en=1 into empty queue at edge N -> regWrite=1, writeReg=5, writeData=0x11111111 during cycle after edge N+1 only; count returns to 0.
REQ-031 drain_en=0, push 4 entries r1..r4 with data 1..4 -> full=1, in_ready=0, count=4; fifth in_valid ignored; then drain_en=1 -> four consecutive regWrite pulses in order r1..r4, data 1..4.
REQ-032 Queue holds r7=0xA then r7=0xB, lookup_reg=7 -> lookup_hit=1, lookup_data=0xB; lookup_reg=0 -> hit=0, data=0; lookup_reg=8 -> hit=0.
REQ-033 Push r0=0xDEAD -> in_ready=1 handshake completes, count stays 0, no regWrite pulse.
REQ-034 Queue with 3 entries, reset pulsed asynchronously mid-cycle -> count=0, empty=1, regWrite=0 immediately; no queued entry issued after reset release.
REQ-035 Continuous push and pop at DEPTH=4 for 10 entries -> count constant at 1, pointer wrap observed, all 10 issued in order with correct data.
